// File: rtl/oc_pkg.sv
// Shared constants and types for the ones-counter arbiter slice.
// Also holds the helper that sizes frame accumulators.
package oc_pkg;

  localparam int unsigned DIN_W = 7;
  localparam int unsigned CNT_W = 3;

  typedef logic [0:0] req_id_t;

  // Smallest accumulator width that holds 7*frame_len without wrapping.
  function automatic int unsigned min_acc_w(input int unsigned frame_len);
    return $clog2(7 * frame_len + 1);
  endfunction

endpackage

// File: rtl/OC_7in.sv
// Seven-input ones counter: combinational popcount of one 7-bit word.
module OC_7in
  import oc_pkg::*;
(
  input  logic [DIN_W-1:0] din_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < DIN_W; i++) begin
      cnt_o = cnt_o + CNT_W'(din_i[i]);
    end
  end

endmodule

// File: rtl/oc_share_arbiter.sv
// Two requesters share one OC_7in via a round-robin arbiter; per-requester
// accumulators total the popcounts over frames and pulse done on completion.
module oc_share_arbiter
  import oc_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned ACC_W     = min_acc_w(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [DIN_W-1:0] din0,
  input  logic [DIN_W-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [ACC_W-1:0] sum0,
  output logic [ACC_W-1:0] sum1,
  output logic             done0,
  output logic             done1
);

  localparam logic [7:0] LastIdx = 8'(FRAME_LEN - 1);

  req_id_t          prio_q;
  logic             pv_q;
  req_id_t          pid_q;
  logic [CNT_W-1:0] pcnt_q;
  logic [ACC_W-1:0] acc_q  [2];
  logic [7:0]       wcnt_q [2];
  logic [ACC_W-1:0] sum_q  [2];
  logic [1:0]       done_q;

  logic             accept;
  req_id_t          gid;
  logic [DIN_W-1:0] mux_din;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] pcnt_ext;

  // Lone requester always wins; on contention the pointer decides.
  always_comb begin
    gnt0     = req0 & (~req1 | (prio_q == 1'b0));
    gnt1     = req1 & (~req0 | (prio_q == 1'b1));
    accept   = gnt0 | gnt1;
    gid      = req_id_t'(gnt1);
    mux_din  = gnt1 ? din1 : din0;
    pcnt_ext = ACC_W'(pcnt_q);
  end

  OC_7in u_oc (
    .din_i (mux_din),
    .cnt_o (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= '0;
      pv_q   <= 1'b0;
      pid_q  <= '0;
      pcnt_q <= '0;
      done_q <= '0;
      for (int i = 0; i < 2; i++) begin
        acc_q[i]  <= '0;
        wcnt_q[i] <= '0;
        sum_q[i]  <= '0;
      end
    end else begin
      pv_q <= accept;
      if (accept) begin
        prio_q <= ~gid;
        pid_q  <= gid;
        pcnt_q <= cnt;
      end
      done_q <= '0;
      if (pv_q) begin
        if (wcnt_q[pid_q] == LastIdx) begin
          sum_q[pid_q]  <= acc_q[pid_q] + pcnt_ext;
          acc_q[pid_q]  <= '0;
          wcnt_q[pid_q] <= '0;
          done_q[pid_q] <= 1'b1;
        end else begin
          acc_q[pid_q]  <= acc_q[pid_q] + pcnt_ext;
          wcnt_q[pid_q] <= wcnt_q[pid_q] + 8'd1;
        end
      end
    end
  end

  assign sum0  = sum_q[0];
  assign sum1  = sum_q[1];
  assign done0 = done_q[0];
  assign done1 = done_q[1];

endmodule

// File: tb/tb_oc_share_arbiter.sv
// Directed bench for oc_share_arbiter: arbitration vector table plus
// hand-written frame sequences with hand-computed sums and pulse cycles.
module tb_oc_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [6:0] din0, din1;
  logic       gnt0, gnt1;
  logic [5:0] sum0, sum1;
  logic       done0, done1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic r0;
    logic r1;
    logic g0;
    logic g1;
  } arb_vec_t;

  arb_vec_t vecs [9];

  oc_share_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .din0  (din0),
    .din1  (din1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .sum0  (sum0),
    .sum1  (sum1),
    .done0 (done0),
    .done1 (done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    cyc();
    rst  = 1'b0;
  endtask

  initial begin
    // Arbitration sequence from prio=0; pointer state carries row to row.
    vecs[0] = '{r0: 1'b0, r1: 1'b0, g0: 1'b0, g1: 1'b0};
    vecs[1] = '{r0: 1'b1, r1: 1'b1, g0: 1'b1, g1: 1'b0};
    vecs[2] = '{r0: 1'b1, r1: 1'b1, g0: 1'b0, g1: 1'b1};
    vecs[3] = '{r0: 1'b0, r1: 1'b1, g0: 1'b0, g1: 1'b1};
    vecs[4] = '{r0: 1'b1, r1: 1'b1, g0: 1'b1, g1: 1'b0};
    vecs[5] = '{r0: 1'b0, r1: 1'b0, g0: 1'b0, g1: 1'b0};
    vecs[6] = '{r0: 1'b1, r1: 1'b1, g0: 1'b0, g1: 1'b1};
    vecs[7] = '{r0: 1'b1, r1: 1'b0, g0: 1'b1, g1: 1'b0};
    vecs[8] = '{r0: 1'b1, r1: 1'b1, g0: 1'b0, g1: 1'b1};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; din0 = '0; din1 = '0;
    #1;

    // Reset held two cycles with no requests.
    cyc();
    cyc();
    check("reset sum0", int'(sum0), 0);
    check("reset sum1", int'(sum1), 0);
    check("reset done0", int'(done0), 0);
    check("reset done1", int'(done1), 0);

    // Solo: 8 words of 7F from cycle N; done0 only in N+9 with sum 56.
    rst = 1'b0;
    din0 = 7'h7F;
    for (int c = 0; c < 12; c++) begin
      req0 = (c < 8);
      #1;
      check($sformatf("solo gnt0 c%0d", c), int'(gnt0), (c < 8) ? 1 : 0);
      check($sformatf("solo done0 c%0d", c), int'(done0), (c == 9) ? 1 : 0);
      if (c == 9) check("solo sum0", int'(sum0), 56);
      cyc();
    end

    // Arbitration table.
    do_reset();
    din0 = 7'h00; din1 = 7'h00;
    for (int i = 0; i < 9; i++) begin
      req0 = vecs[i].r0;
      req1 = vecs[i].r1;
      #1;
      check($sformatf("arb gnt0 v%0d", i), int'(gnt0), int'(vecs[i].g0));
      check($sformatf("arb gnt1 v%0d", i), int'(gnt1), int'(vecs[i].g1));
      cyc();
    end

    // Contention: alternating grants, done0 at 16 (sum 8), done1 at 17 (sum 16).
    do_reset();
    din0 = 7'b0000001; din1 = 7'b0000011;
    for (int c = 0; c < 20; c++) begin
      req0 = (c < 16);
      req1 = (c < 16);
      #1;
      check($sformatf("cont gnt0 c%0d", c), int'(gnt0), (c < 16 && c % 2 == 0) ? 1 : 0);
      check($sformatf("cont gnt1 c%0d", c), int'(gnt1), (c < 16 && c % 2 == 1) ? 1 : 0);
      check($sformatf("cont done0 c%0d", c), int'(done0), (c == 16) ? 1 : 0);
      check($sformatf("cont done1 c%0d", c), int'(done1), (c == 17) ? 1 : 0);
      if (c == 16) check("cont sum0", int'(sum0), 8);
      if (c == 17) check("cont sum1", int'(sum1), 16);
      cyc();
    end

    // Sum hold: requester 1 idle while requester 0 runs 20 cycles.
    din0 = 7'h55;
    req0 = 1'b1; req1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      check($sformatf("hold sum1 c%0d", c), int'(sum1), 16);
      check($sformatf("hold done1 c%0d", c), int'(done1), 0);
      cyc();
    end

    // Back-to-back frames of 7'h0F: done0 at 9 and 17, sum 32 each.
    do_reset();
    din0 = 7'h0F;
    for (int c = 0; c < 20; c++) begin
      req0 = (c < 16);
      #1;
      check($sformatf("b2b done0 c%0d", c), int'(done0), (c == 9 || c == 17) ? 1 : 0);
      if (c == 9 || c == 17) check($sformatf("b2b sum0 c%0d", c), int'(sum0), 32);
      cyc();
    end

    // Reset mid-frame: 3 words of 7F, rst with a granted word, then 8 words of 01.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      rst  = (c == 3);
      req0 = (c < 12);
      req1 = (c == 4);
      din0 = (c < 4) ? 7'h7F : 7'h01;
      din1 = 7'h7F;
      #1;
      if (c == 3) check("mid rst gnt0", int'(gnt0), 1);
      if (c == 4) begin
        check("mid prio gnt0", int'(gnt0), 1);
        check("mid prio gnt1", int'(gnt1), 0);
      end
      check($sformatf("mid done0 c%0d", c), int'(done0), (c == 13) ? 1 : 0);
      check($sformatf("mid done1 c%0d", c), int'(done1), 0);
      if (c == 13) check("mid sum0", int'(sum0), 8);
      cyc();
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Single pipe slot: the two done pulses never coincide.
  always @(negedge clk) begin
    if (done0 && done1) begin
      errors++;
      $display("FAIL done overlap: got done0=1 done1=1, expected at most one");
    end
  end

endmodule

// File: doc/oc_share_arbiter.md
# oc_share_arbiter

Shares one 7-input ones-counter datapath (`OC_7in`) between two requesters. A round-robin arbiter picks one 7-bit word per cycle, and the shared counter computes its popcount. Per-requester accumulators total the popcounts over frames of `FRAME_LEN` words and report each frame sum with a one-cycle done pulse. The block sits between word producers and any logic consuming per-frame ones totals.

## Interface
- `FRAME_LEN`, default 8: accepted words per frame, per requester; legal range 2..255.
- `ACC_W`, default 6: sum/accumulator width; must satisfy 2^ACC_W > 7*FRAME_LEN.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `req0`, `req1` in 1: requester i has a valid word on `din_i`; held until granted.
- `din0`, `din1` in 7: data words.
- `gnt0`, `gnt1` out 1: combinational grant; word i is accepted in any cycle where `req_i & gnt_i`.
- `sum0`, `sum1` out ACC_W: last completed frame total for requester i; holds until the next frame completes.
- `done0`, `done1` out 1: one-cycle pulse, valid in the same cycle the new `sum_i` is visible.

## Operation
- Arbitration:
  - Priority pointer `prio` is 0 after reset.
  - Only one `req` high: grant it.
  - Both high: grant `prio`.
  - After any grant, `prio` becomes the non-granted id.
  - No `req`: no grant, `prio` unchanged.
  - At most one grant per cycle; `gnt_i` is never high without `req_i`.
- Datapath: the granted `din` is muxed into `OC_7in`, giving a 3-bit count 0..7.
- Stage register at the acceptance edge: `pv <= 1`, `pid <=` granted id, `pcnt <=` count. With no grant, `pv <= 0`.
- Accumulate stage (when `pv`), for requester `pid`:
  - `wcnt[pid]` (8 bits) not yet at `FRAME_LEN-1`: `acc[pid] += pcnt`, `wcnt[pid]++`.
  - `wcnt[pid] == FRAME_LEN-1`: `sum[pid] <= acc[pid] + pcnt`, `acc <= 0`, `wcnt <= 0`, `done[pid] <= 1`.
  - All other cases: `done <= 0`.
- Arithmetic is unsigned. `pcnt` is zero-extended to ACC_W. No overflow handling is needed given the ACC_W rule.
- The requesters' frames are independent, and interleaving does not affect either total.
- Reset clears `prio`, `pv`, `pid`, `pcnt`, both `acc`, `wcnt`, `sum`, and `done`. Reset values of all outputs: `gnt0`/`gnt1` follow requests (combinational), `sum0`=`sum1`=0, `done0`=`done1`=0.

## Timing
- Word accepted in cycle N:
  - Registered into the pipe at the end of N.
  - Accumulated at the end of N+1.
  - If it is the frame's last word, `done_i` and the new `sum_i` are visible in cycle N+2, and `done_i` falls in N+3 unless another frame completes.
- Throughput: one word per cycle in total; with both requesters active, each gets one word every 2 cycles.
- `done0` and `done1` are never high in the same cycle (single pipe slot).
- `rst` high during cycle N:
  - `gnt` is still computed combinationally, but any word accepted in N is discarded.
  - In-flight pipe contents and partial frames are lost.
  - The first edge after `rst` falls is a fresh start with `prio`=0.
- A word accepted the cycle a frame completes starts the next frame with no bubble.

## Structure
- Shared package `oc_pkg`: `DIN_W`=7, `CNT_W`=3, `typedef logic [0:0] req_id_t`, and the function computing minimum ACC_W from FRAME_LEN.
- One sub-module: existing `OC_7in`, instantiated once on the muxed word. The arbiter, pipe register, and two accumulators are local logic.

## Test plan
- Reset: assert `rst` 2 cycles with `req`=0 -> `sum0`=`sum1`=0, `done`=0; `req0`=1 after reset -> `gnt0`=1 in the same cycle.
- Solo: `req0`=1, `din0`=7'h7F for 8 consecutive cycles starting N -> `gnt0` every cycle, `done0`=1 only in N+9, `sum0`=56.
- Contention: both `req` held, `din0`=7'b0000001, `din1`=7'b0000011 -> grants alternate 0,1,0,1…; `done0` with `sum0`=8 after 16 cycles, then `done1` one cycle later with `sum1`=16.
- Back-to-back frames: `req0` held for 16 words of 7'h0F -> two `done0` pulses 8 cycles apart, `sum0`=32 both times, no gap.
- Reset mid-frame: 3 words of 7'h7F accepted, then `rst` 1 cycle, then 8 words of 7'h01 -> `sum0`=8 (no leftover 21); `prio` restarts at 0.
- Sum hold: after a `done1` with `sum1`=16, `req1` idle 20 cycles while requester 0 runs -> `sum1` stays 16, `done1` stays 0.
